// File: rtl/mc51_mem_resp_pkg.sv
// Shared state encodings and request-type codes for the MC51 memory responder.
package global_param;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] REQ_PRG_RD = 2'd0;
    localparam logic [1:0] REQ_DAT_RD = 2'd1;
    localparam logic [1:0] REQ_WRITE  = 2'd2;

    // A write strobe dominates; a read with PSEN low is a program fetch.
    function automatic logic [1:0] decode_req(input logic we_n, input logic psen_n);
        if (!we_n) begin
            return REQ_WRITE;
        end
        if (!psen_n) begin
            return REQ_PRG_RD;
        end
        return REQ_DAT_RD;
    endfunction

endpackage

// File: rtl/mc51_iram.sv
// 256x8 internal data RAM: single port, synchronous write, registered read.
module mc51_iram (
    input  logic       clk,
    input  logic       we,
    input  logic       re,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [256];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mc51_mem_resp.sv
// MC51 memory responder: decodes CPU strobes, services program ROM / IRAM
// accesses with configurable wait states and returns a one-cycle ready pulse.
module mc51_mem_resp
    import global_param::*;
#(
    parameter int unsigned PRG_WAIT = 0,
    parameter int unsigned DAT_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic [7:0]  i_mem_wdata,
    input  logic        i_rd_n,
    input  logic        i_we_n,
    input  logic        i_psen_n,
    output logic [7:0]  o_mem_rdata,
    output logic        o_data_rdy,
    output logic        o_bus_err,
    output logic [15:0] o_prg_addr,
    output logic        o_prg_en,
    input  logic [7:0]  i_prg_rdata
);

    localparam logic [3:0] PRG_WAIT_C = 4'(PRG_WAIT);
    localparam logic [3:0] DAT_WAIT_C = 4'(DAT_WAIT);

    logic [1:0]  state;
    logic [1:0]  req_type;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        err_q;
    logic [3:0]  wait_cnt;
    logic        post_access;
    logic [7:0]  hold_q;

    logic        req_valid;
    logic [3:0]  wait_load;
    logic [7:0]  src_data;
    logic [7:0]  iram_rdata;
    logic        iram_we;
    logic        iram_re;

    assign req_valid = !i_we_n || !i_rd_n;
    assign wait_load = (req_type == REQ_PRG_RD) ? PRG_WAIT_C : DAT_WAIT_C;
    assign src_data  = (req_type == REQ_PRG_RD) ? i_prg_rdata : iram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_type    <= REQ_DAT_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
            post_access <= 1'b0;
            hold_q      <= '0;
        end else begin
            post_access <= (state == ST_ACCESS);
            // Source data is valid only in the cycle after ACCESS; keep a copy for long waits.
            if (post_access) begin
                hold_q <= src_data;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= i_mem_addr;
                        wdata_q  <= i_mem_wdata;
                        req_type <= decode_req(i_we_n, i_psen_n);
                        err_q    <= !i_we_n && !i_rd_n;
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    wait_cnt <= wait_load;
                    state    <= (wait_load == 4'd0) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                    if (wait_cnt <= 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        iram_we     = (state == ST_ACCESS) && (req_type == REQ_WRITE);
        iram_re     = (state == ST_ACCESS) && (req_type == REQ_DAT_RD);
        o_data_rdy  = (state == ST_RESP);
        o_bus_err   = (state == ST_ACCESS) && err_q;
        o_prg_en    = (state == ST_ACCESS) && (req_type == REQ_PRG_RD);
        o_prg_addr  = o_prg_en ? addr_q : '0;
        o_mem_rdata = '0;
        // With no wait states RESP is the cycle right after ACCESS, so bypass the hold register.
        if ((state == ST_RESP) && (req_type != REQ_WRITE)) begin
            o_mem_rdata = post_access ? src_data : hold_q;
        end
    end

    mc51_iram u_iram (
        .clk   (clk),
        .we    (iram_we),
        .re    (iram_re),
        .addr  (addr_q[7:0]),
        .wdata (wdata_q),
        .rdata (iram_rdata)
    );

endmodule

// File: tb/tb_mc51_mem_resp.sv
// Scoreboard bench for mc51_mem_resp: two instances with different wait
// configurations share one stimulus stream; a monitor checks each response.
module tb_mc51_mem_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        rd_n, we_n, psen_n;

    logic [7:0]  rdata     [2];
    logic        rdy       [2];
    logic        bus_err   [2];
    logic [15:0] prg_addr  [2];
    logic        prg_en    [2];
    logic [7:0]  prg_rdata [2];

    always #5 clk = ~clk;

    mc51_mem_resp #(.PRG_WAIT(0), .DAT_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
        .i_rd_n(rd_n), .i_we_n(we_n), .i_psen_n(psen_n),
        .o_mem_rdata(rdata[0]), .o_data_rdy(rdy[0]), .o_bus_err(bus_err[0]),
        .o_prg_addr(prg_addr[0]), .o_prg_en(prg_en[0]), .i_prg_rdata(prg_rdata[0])
    );

    mc51_mem_resp #(.PRG_WAIT(5), .DAT_WAIT(3)) u_dut1 (
        .clk(clk), .reset(reset), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
        .i_rd_n(rd_n), .i_we_n(we_n), .i_psen_n(psen_n),
        .o_mem_rdata(rdata[1]), .o_data_rdy(rdy[1]), .o_bus_err(bus_err[1]),
        .o_prg_addr(prg_addr[1]), .o_prg_en(prg_en[1]), .i_prg_rdata(prg_rdata[1])
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       rq [2][$];
    int         eq [2][$];
    logic [7:0] mram [2][256];
    int         idle_at [2];
    int         idle_rdata_bad [2];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        if (a == 16'h0100) return 8'hE5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic int lat(input int i, input bit prg);
        if (i == 0) return 0;
        return prg ? 5 : 3;
    endfunction

    // Synchronous program ROMs, one per instance, 1-cycle latency.
    always @(posedge clk) begin
        if (prg_en[0]) prg_rdata[0] <= rom_val(prg_addr[0]);
        if (prg_en[1]) prg_rdata[1] <= rom_val(prg_addr[1]);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [dut%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, i, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a response.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                int   ec;
                if (rq[i].size() > 0 && rq[i][0].cyc < cyc) begin
                    e = rq[i].pop_front();
                    check("rdy_missing", i, 32'(cyc), 32'(e.cyc));
                end
                if (rdy[i]) begin
                    if (rq[i].size() == 0) begin
                        check("rdy_spurious", i, 32'd1, 32'd0);
                    end else begin
                        e = rq[i].pop_front();
                        check("rdy_cycle", i, 32'(cyc), 32'(e.cyc));
                        check("rdata", i, 32'(rdata[i]), 32'(e.data));
                    end
                end else if (rdata[i] !== 8'h00) begin
                    idle_rdata_bad[i]++;
                end
                if (eq[i].size() > 0 && eq[i][0] < cyc) begin
                    ec = eq[i].pop_front();
                    check("bus_err_missing", i, 32'(cyc), 32'(ec));
                end
                if (bus_err[i]) begin
                    if (eq[i].size() == 0) begin
                        check("bus_err_spurious", i, 32'd1, 32'd0);
                    end else begin
                        ec = eq[i].pop_front();
                        check("bus_err_cycle", i, 32'(cyc), 32'(ec));
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request for a single cycle and records what each instance should answer.
    task automatic issue(input logic [15:0] a, input logic [7:0] d, input bit rd, input bit we, input bit psen);
        int   c;
        int   w;
        exp_t e;
        c = cyc;
        for (int i = 0; i < 2; i++) begin
            if ((rd || we) && c >= idle_at[i]) begin
                w = lat(i, !we && psen);
                e.cyc = c + 2 + w;
                if (we) begin
                    mram[i][a[7:0]] = d;
                    e.data = 8'h00;
                    if (rd) eq[i].push_back(c + 1);
                end else if (psen) begin
                    e.data = rom_val(a);
                end else begin
                    e.data = mram[i][a[7:0]];
                end
                rq[i].push_back(e);
                idle_at[i] = c + 3 + w;
            end
        end
        mem_addr  = a;
        mem_wdata = d;
        rd_n      = !rd;
        we_n      = !we;
        psen_n    = !psen;
        idle(1);
        rd_n      = 1'b1;
        we_n      = 1'b1;
        psen_n    = 1'b1;
        mem_addr  = ~a;
        mem_wdata = ~d;
    endtask

    task automatic do_reset();
        int r;
        r = cyc;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            while (rq[i].size() > 0 && rq[i][rq[i].size() - 1].cyc > r) void'(rq[i].pop_back());
            while (eq[i].size() > 0 && eq[i][eq[i].size() - 1] > r) void'(eq[i].pop_back());
            idle_at[i] = r + 1;
        end
        idle(1);
        reset = 1'b0;
    endtask

    logic [7:0] bnd_addr [3];
    logic [7:0] bnd_data [3];
    int         pen_cnt [2];

    initial begin
        reset     = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_n      = 1'b1;
        we_n      = 1'b1;
        psen_n    = 1'b1;
        idle_rdata_bad[0] = 0;
        idle_rdata_bad[1] = 0;
        idle(3);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("reset_rdy", i, 32'(rdy[i]), 32'd0);
            check("reset_bus_err", i, 32'(bus_err[i]), 32'd0);
            check("reset_prg_en", i, 32'(prg_en[i]), 32'd0);
            check("reset_prg_addr", i, 32'(prg_addr[i]), 32'd0);
            check("reset_rdata", i, 32'(rdata[i]), 32'd0);
            idle_at[i] = cyc;
        end
        mon_en = 1'b1;

        // Program fetch, ROM[0x0100] = E5.
        issue(16'h0100, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(10);
        // Write A5 to 0x30 then read it back.
        issue(16'h0030, 8'hA5, 1'b0, 1'b1, 1'b0);
        idle(10);
        issue(16'h0030, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(10);
        // High address byte ignored on data accesses.
        issue(16'h0030, 8'h5A, 1'b0, 1'b1, 1'b0);
        idle(10);
        issue(16'h1230, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(10);
        // Write and read strobes together: serviced as write with a bus error.
        issue(16'h0040, 8'h11, 1'b1, 1'b1, 1'b0);
        idle(10);
        issue(16'h0040, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(10);
        // Back-to-back: program fetch then data read three cycles later.
        issue(16'h0200, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(2);
        issue(16'h0040, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(10);
        // Reset while dut1 sits in WAIT; next fetch must still take 2+PRG_WAIT.
        issue(16'h0123, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(3);
        do_reset();
        issue(16'h0100, 8'h00, 1'b1, 1'b0, 1'b1);
        idle(10);
        // Address boundaries, read back with a non-zero high byte.
        bnd_addr[0] = 8'h00; bnd_data[0] = 8'h3C;
        bnd_addr[1] = 8'hFF; bnd_data[1] = 8'hC3;
        bnd_addr[2] = 8'h7F; bnd_data[2] = 8'h81;
        for (int k = 0; k < 3; k++) begin
            issue({8'h00, bnd_addr[k]}, bnd_data[k], 1'b0, 1'b1, 1'b0);
            idle(8);
        end
        for (int k = 0; k < 3; k++) begin
            issue({8'hFF, bnd_addr[k]}, 8'h00, 1'b1, 1'b0, 1'b0);
            idle(8);
        end
        // PSEN alone is not a request.
        pen_cnt[0] = 0;
        pen_cnt[1] = 0;
        psen_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            for (int i = 0; i < 2; i++) if (prg_en[i]) pen_cnt[i]++;
        end
        psen_n = 1'b1;
        idle(12);
        for (int i = 0; i < 2; i++) begin
            check("psen_only_prg_en", i, 32'(pen_cnt[i]), 32'd0);
            check("rdy_pending", i, 32'(rq[i].size()), 32'd0);
            check("bus_err_pending", i, 32'(eq[i].size()), 32'd0);
            check("rdata_nonzero_outside_resp", i, 32'(idle_rdata_bad[i]), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc51_mem_resp.md
MC51_MEM_RESP -- requirements
Module: mc51_mem_resp

Interface
REQ-001 SHALL have parameter PRG_WAIT, default 0, extra wait cycles on program reads (range 0-15).
REQ-002 SHALL have parameter DAT_WAIT, default 0, extra wait cycles on data reads and writes (range 0-15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_mem_addr  input  16  address driven by the CPU control unit.
REQ-006 SHALL have port i_mem_wdata  input  8  write data.
REQ-007 SHALL have ports i_rd_n, i_we_n, i_psen_n  input  1 each  active-low strobes.
REQ-008 SHALL have port o_mem_rdata  output  8  read data, valid while o_data_rdy=1.
REQ-009 SHALL have port o_data_rdy  output  1  one-cycle completion pulse.
REQ-010 SHALL have port o_bus_err  output  1  one-cycle pulse on an illegal strobe combination.
REQ-011 SHALL have ports o_prg_addr  output  16, o_prg_en  output  1, i_prg_rdata  input  8  for synchronous program ROM with 1-cycle read latency.

Function
REQ-012 Request decode, sampled only in IDLE: i_we_n=0 is a WRITE; i_rd_n=0 with i_psen_n=0 is a PRG_RD; i_rd_n=0 with i_psen_n=1 is a DAT_RD; i_psen_n=0 alone is not a request.
REQ-013 i_we_n=0 and i_rd_n=0 together SHALL be serviced as WRITE, with o_bus_err pulsed in the first ACCESS cycle.
REQ-014 Address, write data and request type SHALL be captured on the IDLE->ACCESS edge; later input changes SHALL have no effect on the transaction.
REQ-015 FSM states: IDLE -> ACCESS (1 cycle) -> WAIT (PRG_WAIT or DAT_WAIT cycles, skipped when 0) -> RESP (1 cycle) -> IDLE.
REQ-016 Request sampled in cycle N SHALL yield o_data_rdy=1 in cycle N+2+WAIT and in no other cycle.
REQ-017 In ACCESS: PRG_RD drives o_prg_en=1 with o_prg_addr set to the captured address; DAT_RD reads IRAM at addr[7:0]; WRITE commits wdata to IRAM at addr[7:0]. addr[15:8] SHALL be ignored for data accesses.
REQ-018 Read data SHALL be registered at the end of the cycle after ACCESS and held stable through RESP; o_mem_rdata SHALL be 0 on writes and in all non-RESP cycles.
REQ-019 In the RESP cycle the CPU releases its strobes combinationally; strobe levels SHALL be ignored in RESP, and a new request SHALL be accepted in the cycle immediately after RESP.
REQ-020 Back-to-back operation: PRG_RD in cycle N followed by DAT_RD asserted in N+3 (WAIT=0) SHALL complete in N+5.
REQ-021 Read-after-write to the same IRAM address SHALL return the new data.
REQ-022 The wait counter SHALL be 4 bits wide, load WAIT on ACCESS, and decrement to 0 without wrap-around.

Reset
REQ-023 With reset=1 at a clock edge: FSM -> IDLE, wait counter=0, o_data_rdy=0, o_bus_err=0, o_prg_en=0, o_prg_addr=0, o_mem_rdata=0.
REQ-024 Reset during WAIT or RESP SHALL drop the transaction with no o_data_rdy pulse; a write already committed in ACCESS SHALL remain committed.
REQ-025 IRAM contents SHALL NOT be cleared by reset.

Structure
REQ-026 State encoding and request-type codes (PRG_RD, DAT_RD, WRITE) SHALL live in the shared global_param package.
REQ-027 Data storage SHALL be a sub-module mc51_iram: 256x8, single port, synchronous write, 1-cycle registered read.

Verification
REQ-028 WAIT=0: PRG_RD at 16'h0100 with ROM[0x100]=8'hE5, request in cycle 10 -> o_data_rdy=1 and o_mem_rdata=8'hE5 in cycle 12 only.
REQ-029 DAT_WAIT=3: WRITE 8'hA5 to 16'h0030, then DAT_RD 16'h0030 -> first rdy at request+5, read returns 8'hA5 at request+5.
REQ-030 DAT_RD 16'h1230 after writing 8'h5A to 0x30 -> returns 8'h5A (high byte ignored).
REQ-031 i_we_n=0 and i_rd_n=0 with wdata 8'h11 at 0x40 -> o_bus_err pulses once, write performed, o_mem_rdata=0 at rdy, later read of 0x40 returns 8'h11.
REQ-032 PRG_WAIT=5: reset asserted during WAIT -> no o_data_rdy; next request completes in exactly 7 cycles (2+5).
REQ-033 i_psen_n=0 with i_rd_n=1 for 20 cycles -> o_prg_en stays 0, no o_data_rdy.
